vga_plot_arbiter: RTL and testbench

Shares the single VGA adapter write port (x, y, colour, plot) among three drawing engines: the screen-clear engine (requester 0), the falling-piece drawer (requester 1) and the score drawer (requester 2). It latches draw requests, grants the port to one engine at a time by fixed priority, and pulses that engine's go input. It muxes the granted engine's pixel stream to the VGA adapter and releases the port on the engine's done, or on a watchdog timeout.

---
 rtl/vga_plot_arbiter.sv | 120 ++++++++++++
 tb/tb_vga_plot_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Fixed-priority owner of the single VGA adapter write port: latches requests, starts one
// drawing engine at a time and forwards its pixel stream until done or watchdog expiry.
module vga_plot_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 32768,
    parameter int TO_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [7*N_REQ-1:0]   in_x,
    input  logic [7*N_REQ-1:0]   in_y,
    input  logic [3*N_REQ-1:0]   in_colour,
    input  logic [N_REQ-1:0]     in_plot,
    output logic [N_REQ-1:0]     go,
    output logic [6:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic [1:0]           grant,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] grant_onehot;
    logic [N_REQ-1:0] pending_clr;
    logic [1:0]       lowest;
    logic [TO_W-1:0]  watchdog;
    logic             expire;
    logic [6:0]       sel_x, sel_y;
    logic [2:0]       sel_colour;
    logic             sel_plot, sel_done;

    // Lowest set index wins: scan from the top so the smallest index is written last.
    always_comb begin
        lowest = 2'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) lowest = 2'(i);
        end
    end

    always_comb begin
        grant_onehot = '0;
        sel_x        = 7'd0;
        sel_y        = 7'd0;
        sel_colour   = 3'd0;
        sel_plot     = 1'b0;
        sel_done     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == 2'(i)) begin
                grant_onehot[i] = 1'b1;
                sel_x           = in_x[7*i +: 7];
                sel_y           = in_y[7*i +: 7];
                sel_colour      = in_colour[3*i +: 3];
                sel_plot        = in_plot[i];
                sel_done        = done[i];
            end
        end
    end

    assign expire      = (watchdog == TO_W'(TIMEOUT - 1));
    // A request arriving in the issue cycle re-arms the owner's pending bit (set beats clear).
    assign pending_clr = (state == ISSUE) ? grant_onehot : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            grant       <= 2'd0;
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~pending_clr) | req;
            if (state == IDLE && |pending)
                grant <= lowest;
            if (state == ISSUE)
                watchdog <= '0;
            else if (state == BUSY)
                watchdog <= watchdog + 1'b1;
            if (state == BUSY && !sel_done && expire)
                timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (sel_done || expire) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The pixel path is only open while BUSY, so RELEASE leaves a dead cycle between owners.
    always_comb begin
        go         = '0;
        vga_x      = 7'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        busy       = (state != IDLE);
        if (state == ISSUE)
            go = grant_onehot;
        if (state == BUSY) begin
            vga_x      = sel_x;
            vga_y      = sel_y;
            vga_colour = sel_colour;
            vga_plot   = sel_plot;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed and random stimulus for vga_plot_arbiter, compared every cycle against a
// cycle-level reference model of the arbitration rules.
module tb_vga_plot_arbiter;

    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0, done = '0, in_plot = '0;
    logic [20:0] in_x = '0, in_y = '0;
    logic [8:0]  in_colour = '0;
    logic [2:0]  go;
    logic [6:0]  vga_x, vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, timeout_err;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 issue, 2 busy, 3 release
    int         m_phase, m_grant, m_wd;
    logic [2:0] m_pend;
    logic       m_terr;

    always #5 clock = ~clock;

    vga_plot_arbiter #(.N_REQ(3), .TIMEOUT(T), .TO_W(16)) dut (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
        .go(go), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    function automatic logic [24:0] observed();
        return {go, vga_x, vga_y, vga_colour, vga_plot, busy, grant, timeout_err};
    endfunction

    function automatic logic [24:0] expected();
        logic [2:0] eg, ec;
        logic [6:0] ex, ey;
        logic       ep;
        eg = '0; ec = '0; ex = '0; ey = '0; ep = 1'b0;
        if (m_phase == 1) eg = 3'b001 << m_grant;
        if (m_phase == 2) begin
            ex = in_x[7*m_grant +: 7];
            ey = in_y[7*m_grant +: 7];
            ec = in_colour[3*m_grant +: 3];
            ep = in_plot[m_grant];
        end
        return {eg, ex, ey, ec, ep, (m_phase != 0), 2'(m_grant), m_terr};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_grant = 0; m_wd = 0; m_pend = '0; m_terr = 1'b0;
    endtask

    task automatic model_update();
        logic [2:0] np;
        np = m_pend | req;
        case (m_phase)
            0: if (m_pend != 0) begin
                   for (int i = 2; i >= 0; i--) if (m_pend[i]) m_grant = i;
                   m_phase = 1;
               end
            1: begin
                   np = (m_pend & ~(3'b001 << m_grant)) | req;
                   m_wd = 0;
                   m_phase = 2;
               end
            2: begin
                   if (done[m_grant]) m_phase = 3;
                   else if (m_wd == T - 1) begin m_phase = 3; m_terr = 1'b1; end
                   m_wd++;
               end
            default: m_phase = 0;
        endcase
        m_pend = np;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag);
        @(negedge clock);
        check(tag, {7'd0, observed()}, {7'd0, expected()});
    endtask

    task automatic cycle();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic tick(input string tag);
        sample(tag);
        cycle();
    endtask

    task automatic drain();
        done = 3'b111;
        for (int i = 0; i < 10; i++) tick("drain");
        done = 3'b000;
        tick("drain_idle");
    endtask

    initial begin
        int  run;
        bit  ended, saw_go2, saw_go0;
        logic [2:0] goq[$];

        model_reset();
        sample("reset_state");
        reset = 1'b0;
        cycle();

        // Single request from the piece drawer, done on the tenth busy cycle
        in_x = 21'd5 << 7; in_y = 21'd9 << 7; in_colour = 9'b100 << 3; in_plot = 3'b010;
        req = 3'b010;
        tick("t1_req");
        req = 3'b000;
        sample("t1_idle");
        check("t1_go_not_yet", {29'd0, go}, 32'd0);
        cycle();
        sample("t1_issue");
        check("t1_go", {29'd0, go}, 32'b010);
        cycle();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) done = 3'b010;
            sample("t1_busy");
            check("t1_pix", {14'd0, vga_x, vga_y, vga_colour, vga_plot}, {14'd0, 7'd5, 7'd9, 3'b100, 1'b1});
            cycle();
        end
        done = 3'b000;
        sample("t1_release");
        check("t1_busy_release", {31'd0, busy}, 32'd1);
        cycle();
        sample("t1_idle_after");
        check("t1_busy_drop", {31'd0, busy}, 32'd0);
        cycle();

        // Simultaneous requests 1 and 2: priority order of go pulses
        in_x = {7'd22, 7'd11, 7'd0}; in_y = {7'd33, 7'd44, 7'd0};
        in_colour = {3'b111, 3'b010, 3'b000}; in_plot = 3'b110;
        req = 3'b110;
        tick("t2_req");
        req = 3'b000;
        done = 3'b110;
        for (int i = 0; i < 12; i++) begin
            sample("t2_run");
            if (go != 3'b000) goq.push_back(go);
            cycle();
        end
        done = 3'b000;
        check("t2_go_count", goq.size(), 2);
        if (goq.size() == 2) begin
            check("t2_first_go", {29'd0, goq[0]}, 32'b010);
            check("t2_second_go", {29'd0, goq[1]}, 32'b100);
        end
        drain();

        // Requester 2 owns the port; request 0 and done[0] arrive mid-busy
        in_plot = 3'b111; in_x = {7'd70, 7'd60, 7'd50};
        req = 3'b100;
        tick("t3_req");
        req = 3'b000;
        tick("t3_idle");
        tick("t3_issue");
        req = 3'b001; done = 3'b001;
        tick("t3_busy_req0");
        req = 3'b000;
        tick("t3_busy_done0");
        tick("t3_busy_done0b");
        sample("t3_hold");
        check("t3_no_preempt", {29'd0, busy, grant}, {29'd0, 1'b1, 2'd2});
        cycle();
        done = 3'b100;
        tick("t3_done2");
        done = 3'b000;
        saw_go0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample("t3_next");
            if (go == 3'b001 && grant == 2'd0) saw_go0 = 1'b1;
            cycle();
        end
        check("t3_go0_after_release", {31'd0, saw_go0}, 32'd1);
        drain();

        // Watchdog expiry with no done; request 2 waits and is still served
        sample("t5_pre");
        check("t5_terr_clear", {31'd0, timeout_err}, 32'd0);
        cycle();
        req = 3'b010;
        tick("t5_req");
        req = 3'b000;
        run = 0; ended = 1'b0; saw_go2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            req = (i == 5) ? 3'b100 : 3'b000;
            sample("t5_run");
            if (!ended) begin
                if (busy) run++;
                else if (run > 0) ended = 1'b1;
            end
            if (go == 3'b100) saw_go2 = 1'b1;
            cycle();
        end
        req = 3'b000;
        check("t5_busy_len", run, T + 2);
        check("t5_next_served", {31'd0, saw_go2}, 32'd1);
        check("t5_terr_sticky", {31'd0, timeout_err}, 32'd1);
        drain();

        // Asynchronous reset in the middle of a busy period
        req = 3'b001;
        tick("t6_req");
        req = 3'b010;
        tick("t6_idle");
        req = 3'b000;
        tick("t6_issue");
        in_plot = 3'b001;
        sample("t6_busy");
        check("t6_plot_on", {31'd0, vga_plot}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t6_async_drop", {25'd0, go, vga_plot, busy, timeout_err}, 32'd0);
        model_reset();
        #1 reset = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) tick("t6_pending_cleared");
        req = 3'b001;
        tick("t6_req0");
        req = 3'b000;
        tick("t6_idle0");
        sample("t6_issue0");
        check("t6_go0", {29'd0, go}, 32'b001);
        cycle();
        drain();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req       = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            done      = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            in_x      = 21'($urandom);
            in_y      = 21'($urandom);
            in_colour = 9'($urandom);
            in_plot   = 3'($urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
